// File: rtl/bpm_band_fusion_if.sv
// Band BPM/weight inputs and fused-tempo outputs of bpm_band_fusion.
// master drives the band estimates; slave is the fusion block.
interface bpm_band_fusion_if #(
  parameter int unsigned NBANDS   = 3,
  parameter int unsigned BPM_W    = 16,
  parameter int unsigned WEIGHT_W = 4
);
  logic [NBANDS*BPM_W-1:0]    bpm_in;
  logic [NBANDS-1:0]          bpm_valid_in;
  logic [NBANDS*WEIGHT_W-1:0] band_weight;
  logic [BPM_W-1:0]           fused_bpm;
  logic                       fused_valid;
  logic                       beat_pulse;
  logic                       locked;
  logic                       busy;

  modport master (
    output bpm_in, bpm_valid_in, band_weight,
    input  fused_bpm, fused_valid, beat_pulse, locked, busy
  );

  modport slave (
    input  bpm_in, bpm_valid_in, band_weight,
    output fused_bpm, fused_valid, beat_pulse, locked, busy
  );
endinterface

// File: rtl/bpm_band_fusion.sv
// Weighted fusion of per-band BPM estimates, EMA smoothing and a beat-pulse generator.
// Optional octave folding of out-of-range bands: define BPM_FUSION_OCTAVE_FOLD_EN.
module bpm_band_fusion #(
  parameter int unsigned NBANDS       = 3,
  parameter int unsigned BPM_W        = 16,
  parameter int unsigned WEIGHT_W     = 4,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BPM_MIN      = 60,
  parameter int unsigned BPM_MAX      = 200,
  parameter int unsigned SMOOTH_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  bpm_band_fusion_if.slave bus
);
  localparam int unsigned LOG_N  = $clog2(NBANDS);
  localparam int unsigned IDX_W  = (NBANDS > 1) ? LOG_N : 1;
  localparam int unsigned NUM_W  = BPM_W + WEIGHT_W + LOG_N;
  localparam int unsigned DEN_W  = WEIGHT_W + LOG_N;
  localparam int unsigned PER_W  = 32;
  localparam int unsigned DW     = (NUM_W > PER_W) ? NUM_W : PER_W;
  localparam int unsigned DCNT_W = $clog2(DW + 1);
  localparam logic [63:0] BEAT_NUM64 = 64'(CLK_HZ) * 64'd60;
  localparam logic [PER_W-1:0] BEAT_NUM = BEAT_NUM64[PER_W-1:0];

  typedef enum logic [2:0] {IDLE, ACCUM, DIV1, SMOOTH, DIV2} state_t;
  state_t state, state_next;

  logic [BPM_W-1:0]    held     [NBANDS];
  logic [BPM_W-1:0]    snap_bpm [NBANDS];
  logic [WEIGHT_W-1:0] snap_w   [NBANDS];
  logic [NBANDS-1:0]   fresh, nz;
  logic                trig;

  logic [IDX_W-1:0]    idx;
  logic [NUM_W-1:0]    num, num_sum;
  logic [DEN_W-1:0]    den, den_sum;
  logic [BPM_W-1:0]    cur_bpm;
  logic [WEIGHT_W-1:0] cur_w, w_eff;
  logic                in_rng, band_done, last_band;

  logic [DW-1:0]       quo, rem, dvs, quo_nx, rem_nx;
  logic [DW:0]         rem_sh, rem_sub;
  logic                q_bit;
  logic [DCNT_W-1:0]   dcnt;

  logic [BPM_W-1:0]    raw, ema;
  logic signed [BPM_W:0] diff, step;
  logic                ema_loaded;

  logic [BPM_W-1:0]    fused_q;
  logic                fused_valid_q, beat_q, locked_q, busy_q;
  logic [PER_W-1:0]    per_cur, pend, bcnt, period_new;
  logic                pend_v, div2_done;

  // A band takes part in the trigger only if its weight is nonzero
  always_comb begin
    nz = '0;
    for (int k = 0; k < NBANDS; k++)
      nz[k] = |bus.band_weight[k*WEIGHT_W +: WEIGHT_W];
  end

  assign trig = (state == IDLE) && (|nz) && ((fresh & nz) == nz);

`ifdef BPM_FUSION_OCTAVE_FOLD_EN
  localparam int unsigned FCNT_W = $clog2(BPM_W + 1);
  logic [BPM_W-1:0]  fval;
  logic [FCNT_W-1:0] fcnt;
  logic              below, reject;

  // Doubling with the MSB set would overflow, so such a value cannot be folded up
  assign cur_bpm   = fval;
  assign below     = fval < BPM_W'(BPM_MIN);
  assign reject    = !in_rng && ((fval == '0) || (fcnt == FCNT_W'(BPM_W)) ||
                                 (below && fval[BPM_W-1]));
  assign band_done = in_rng || reject;
`else
  assign cur_bpm   = snap_bpm[idx];
  assign band_done = 1'b1;
`endif

  assign cur_w     = snap_w[idx];
  assign in_rng    = (cur_bpm >= BPM_W'(BPM_MIN)) && (cur_bpm <= BPM_W'(BPM_MAX));
  assign w_eff     = in_rng ? cur_w : '0;
  assign num_sum   = num + NUM_W'(w_eff) * NUM_W'(cur_bpm);
  assign den_sum   = den + DEN_W'(w_eff);
  assign last_band = (state == ACCUM) && band_done && (idx == IDX_W'(NBANDS - 1));

  // Restoring divider step: dividend bits leave the top of quo, quotient bits enter at the bottom
  assign rem_sh  = {rem, quo[DW-1]};
  assign rem_sub = rem_sh - {1'b0, dvs};
  assign q_bit   = ~rem_sub[DW];
  assign rem_nx  = q_bit ? rem_sub[DW-1:0] : rem_sh[DW-1:0];
  assign quo_nx  = {quo[DW-2:0], q_bit};

  assign div2_done  = (state == DIV2) && (dcnt == '0);
  assign period_new = quo_nx[PER_W-1:0];

  assign raw  = quo[BPM_W-1:0];
  assign diff = $signed({1'b0, raw}) - $signed({1'b0, fused_q});
  assign step = diff >>> SMOOTH_SHIFT;
  assign ema  = ema_loaded ? BPM_W'($signed({1'b0, fused_q}) + step) : raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (trig) state_next = ACCUM;
      ACCUM:   if (last_band) state_next = (den_sum == '0) ? IDLE : DIV1;
      DIV1:    if (dcnt == '0) state_next = SMOOTH;
      SMOOTH:  state_next = DIV2;
      DIV2:    if (dcnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Band capture runs regardless of FSM state; a same-cycle strobe keeps fresh set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NBANDS; k++) held[k] <= '0;
      fresh <= '0;
    end else begin
      for (int k = 0; k < NBANDS; k++)
        if (bus.bpm_valid_in[k]) held[k] <= bus.bpm_in[k*BPM_W +: BPM_W];
      fresh <= (trig ? '0 : fresh) | bus.bpm_valid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NBANDS; k++) begin
        snap_bpm[k] <= '0;
        snap_w[k]   <= '0;
      end
      idx           <= '0;
      num           <= '0;
      den           <= '0;
      quo           <= '0;
      rem           <= '0;
      dvs           <= '0;
      dcnt          <= '0;
      fused_q       <= '0;
      fused_valid_q <= 1'b0;
      ema_loaded    <= 1'b0;
      busy_q        <= 1'b0;
`ifdef BPM_FUSION_OCTAVE_FOLD_EN
      fval          <= '0;
      fcnt          <= '0;
`endif
    end else begin
      fused_valid_q <= 1'b0;
      busy_q        <= (state_next != IDLE);
      case (state)
        IDLE: if (trig) begin
          for (int k = 0; k < NBANDS; k++) begin
            snap_bpm[k] <= held[k];
            snap_w[k]   <= bus.band_weight[k*WEIGHT_W +: WEIGHT_W];
          end
          idx <= '0;
          num <= '0;
          den <= '0;
`ifdef BPM_FUSION_OCTAVE_FOLD_EN
          fval <= held[0];
          fcnt <= '0;
`endif
        end
        ACCUM: begin
          if (band_done) begin
            num <= num_sum;
            den <= den_sum;
            idx <= idx + IDX_W'(1);
`ifdef BPM_FUSION_OCTAVE_FOLD_EN
            if (!last_band) fval <= snap_bpm[idx + IDX_W'(1)];
            fcnt <= '0;
`endif
          end
`ifdef BPM_FUSION_OCTAVE_FOLD_EN
          else begin
            fval <= below ? (fval << 1) : (fval >> 1);
            fcnt <= fcnt + FCNT_W'(1);
          end
`endif
          if (last_band) begin
            rem  <= '0;
            quo  <= DW'(num_sum) << (DW - NUM_W);
            dvs  <= DW'(den_sum);
            dcnt <= DCNT_W'(NUM_W - 1);
          end
        end
        DIV1, DIV2: begin
          rem  <= rem_nx;
          quo  <= quo_nx;
          dcnt <= dcnt - DCNT_W'(1);
        end
        SMOOTH: begin
          fused_q       <= ema;
          fused_valid_q <= 1'b1;
          ema_loaded    <= 1'b1;
          rem           <= '0;
          quo           <= DW'(BEAT_NUM) << (DW - PER_W);
          dvs           <= DW'(ema);
          dcnt          <= DCNT_W'(PER_W - 1);
        end
        default: ;
      endcase
    end
  end

  // Beat generator: a new period waits in pend until the running beat completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cur  <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      bcnt     <= '0;
      beat_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      if (locked_q) begin
        if (bcnt == per_cur - PER_W'(1)) begin
          bcnt   <= '0;
          beat_q <= 1'b1;
          if (pend_v) begin
            per_cur <= pend;
            pend_v  <= 1'b0;
          end
        end else begin
          bcnt <= bcnt + PER_W'(1);
        end
      end
      if (div2_done) begin
        if (!locked_q) begin
          per_cur  <= period_new;
          bcnt     <= '0;
          locked_q <= 1'b1;
        end else begin
          pend   <= period_new;
          pend_v <= 1'b1;
        end
      end
    end
  end

  assign bus.fused_bpm   = fused_q;
  assign bus.fused_valid = fused_valid_q;
  assign bus.beat_pulse  = beat_q;
  assign bus.locked      = locked_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_bpm_band_fusion.sv
// Directed bench for bpm_band_fusion: scoreboarded fused results, beat spacing and reset behaviour.
module tb_bpm_band_fusion;
  localparam int LAT = 28;
`ifdef BPM_FUSION_OCTAVE_FOLD_EN
  localparam int OOR_BPM = 122;
  localparam int OOR_LAT = 29;
`else
  localparam int OOR_BPM = 120;
  localparam int OOR_LAT = 28;
`endif

  typedef struct {
    int bpm;
    int cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0, checks = 0, errors = 0, drive_cyc = 0, lock_cyc = -1;
  exp_t sb[$];
  int   beats[$];
  logic prev_locked = 1'b0;

  bpm_band_fusion_if #(.NBANDS(3), .BPM_W(16), .WEIGHT_W(4)) bus ();

  bpm_band_fusion #(
    .NBANDS(3), .BPM_W(16), .WEIGHT_W(4), .CLK_HZ(1000),
    .BPM_MIN(60), .BPM_MAX(200), .SMOOTH_SHIFT(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on fused_valid, records lock and beat cycles
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.fused_valid) begin
        chk("fused_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("fused_bpm", bus.fused_bpm, e.bpm);
          chk("fused_latency", cyc, e.cyc);
        end
      end
      if (bus.locked && !prev_locked) lock_cyc = cyc;
      if (bus.beat_pulse) beats.push_back(cyc);
    end
    prev_locked = bus.locked;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_w(input int w0, input int w1, input int w2);
    bus.band_weight = {4'(w2), 4'(w1), 4'(w0)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic strobe(input int b0, input int b1, input int b2, input logic [2:0] mask);
    @(negedge clk);
    bus.bpm_in       = {16'(b2), 16'(b1), 16'(b0)};
    bus.bpm_valid_in = mask;
    drive_cyc        = cyc;
    @(negedge clk);
    bus.bpm_valid_in = '0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    tick(3);
    while (bus.busy !== 1'b0 && n < maxc) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", bus.busy, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_beats(input int n, input int maxc);
    int k = 0;
    while (beats.size() < n && k < maxc) begin
      tick(1);
      k++;
    end
    chk("beat_timeout", 32'(beats.size() >= n), 1);
  endtask

  initial begin
    bus.bpm_in       = '0;
    bus.bpm_valid_in = '0;
    bus.band_weight  = '0;

    // Reset values
    tick(3);
    chk("rst_fused_bpm", bus.fused_bpm, 0);
    chk("rst_fused_valid", bus.fused_valid, 0);
    chk("rst_beat", bus.beat_pulse, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;

    // All-zero weights never trigger
    set_w(0, 0, 0);
    strobe(120, 120, 120, 3'b111);
    tick(2);
    chk("zero_w_busy_a", bus.busy, 0);
    tick(6);
    chk("zero_w_busy_b", bus.busy, 0);
    do_reset();

    // Weighted fusion, first result loads directly
    set_w(2, 2, 1);
    strobe(100, 120, 150, 3'b111);
    sb.push_back('{bpm: 118, cyc: drive_cyc + LAT});
    tick(4);
    chk("weighted_busy", bus.busy, 1);
    wait_idle(200);
    chk("weighted_locked", bus.locked, 1);

    // Out-of-range band 0
    do_reset();
    strobe(250, 120, 120, 3'b111);
    sb.push_back('{bpm: OOR_BPM, cyc: drive_cyc + OOR_LAT});
    wait_idle(200);

    // Only band 2 weighted and strobed
    do_reset();
    set_w(0, 0, 1);
    strobe(0, 0, 120, 3'b100);
    sb.push_back('{bpm: 120, cyc: drive_cyc + LAT});
    wait_idle(200);

    // Unanimous bands, lock and 500-cycle beats
    do_reset();
    set_w(2, 2, 1);
    beats.delete();
    strobe(120, 120, 120, 3'b111);
    sb.push_back('{bpm: 120, cyc: drive_cyc + LAT});
    wait_idle(200);
    chk("unan_locked", bus.locked, 1);
    wait_beats(2, 1200);
    if (beats.size() >= 2) begin
      chk("first_beat_delay", beats[0] - lock_cyc, 500);
      chk("beat_period_500", beats[1] - beats[0], 500);
    end

    // Smoothing 120 -> raw 160 gives 130; period handover only at the next wrap
    tick(10);
    strobe(160, 160, 160, 3'b111);
    sb.push_back('{bpm: 130, cyc: drive_cyc + LAT});
    wait_idle(200);
    wait_beats(5, 1500);
    if (beats.size() >= 5) begin
      chk("handover_old_period", beats[2] - beats[1], 500);
      chk("handover_new_period", beats[3] - beats[2], 461);
      chk("new_period_steady", beats[4] - beats[3], 461);
    end

    // Every band rejected: no output change
    strobe(0, 0, 0, 3'b111);
    wait_idle(100);
    chk("den_zero_hold", bus.fused_bpm, 130);

    // Reset during the first divide clears everything immediately
    strobe(100, 120, 150, 3'b111);
    tick(10);
    chk("pre_reset_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_fused_bpm", bus.fused_bpm, 0);
    chk("midrst_fused_valid", bus.fused_valid, 0);
    chk("midrst_beat", bus.beat_pulse, 0);
    chk("midrst_locked", bus.locked, 0);
    chk("midrst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    strobe(160, 160, 160, 3'b111);
    sb.push_back('{bpm: 160, cyc: drive_cyc + LAT});
    wait_idle(200);
    chk("post_reset_direct", bus.fused_bpm, 160);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpm_band_fusion.md
# bpm_band_fusion

Parametrised successor to the fixed three-band BPM combiner in the BPM estimator top level. It takes `NBANDS` per-band autocorrelation BPM estimates and fuses them with runtime-programmable integer weights, rejecting out-of-range bands. The fused value is smoothed with an exponential moving average, and a free-running beat pulse is generated at the smoothed tempo, driving the estimator's `beat_pulse` output. The block sits between the per-band autocorrelation instances and the video/face logic.

## Interface
- `NBANDS`, 3, number of frequency bands (≥1)
- `BPM_W`, 16, width of each BPM value
- `WEIGHT_W`, 4, width of each band weight
- `CLK_HZ`, 50_000_000, `clk` frequency; beat period numerator is `CLK_HZ*60`
- `BPM_MIN`, 60, lowest accepted band BPM (inclusive)
- `BPM_MAX`, 200, highest accepted band BPM (inclusive)
- `SMOOTH_SHIFT`, 2, EMA shift; 0 disables smoothing
- `clk` in 1 system clock; one clock domain
- `reset` in 1 asynchronous, active-high; clears all state
- `bpm_in` in `NBANDS*BPM_W` band BPMs; band k is at `[k*BPM_W +: BPM_W]`
- `bpm_valid_in` in `NBANDS` per-band one-cycle valid strobes
- `band_weight` in `NBANDS*WEIGHT_W` per-band weights, quasi-static
- `fused_bpm` out `BPM_W` smoothed fused BPM; reset value 0
- `fused_valid` out 1 one-cycle pulse when `fused_bpm` updates; reset value 0
- `beat_pulse` out 1 one-cycle pulse per beat; reset value 0
- `locked` out 1 high once a beat period is loaded; reset value 0
- `busy` out 1 high whenever the FSM is not IDLE; reset value 0

## Operation
- **Band capture.** On `bpm_valid_in[k]`, latch `bpm_in` band k into `held[k]` and set `fresh[k]`. Capture is independent of FSM state.
- **Trigger.** In IDLE, a trigger occurs when every band with nonzero weight has `fresh` set and at least one weight is nonzero. All-zero weights never trigger.
  - At trigger: snapshot `held` and `band_weight`, and clear `fresh`.
  - If a strobe arrives in the trigger cycle, the new value is latched and `fresh` remains set (set wins).
- **FSM states.**
  - IDLE → ACCUM on trigger.
  - ACCUM: one band per cycle for `NBANDS` cycles.
    - Bands outside `[BPM_MIN, BPM_MAX]` contribute weight 0.
    - `num += w*bpm` (width `BPM_W+WEIGHT_W+$clog2(NBANDS)`), `den += w`.
  - ACCUM → IDLE if `den == 0`: no output change, no `fused_valid`. Otherwise ACCUM → DIV1.
  - DIV1: restoring divide, one quotient bit per cycle (num width cycles); result is truncated.
  - SMOOTH (1 cycle):
    - First result after reset loads directly.
    - Otherwise `s += (raw - s) >>> SMOOTH_SHIFT`, using a signed difference and arithmetic shift.
    - Updates `fused_bpm` and pulses `fused_valid`.
  - DIV2: the same divider computes `period = CLK_HZ*60 / fused_bpm` over 32 cycles. Then → IDLE.
- **Beat generator.**
  - Counter runs 0..`period-1`. `beat_pulse` fires on the cycle the counter wraps to 0.
  - A newly computed period is held pending and takes effect at the next wrap, so the current beat is never truncated.
  - `locked` rises when the first period loads. The first beat occurs `period` cycles after the load.
  - Before `locked`, no beats are produced.

## Timing
- Trigger cycle T. ACCUM occupies T+1..T+NBANDS.
- `fused_valid` is asserted at T+NBANDS+NUM_W+2 (22-bit num at defaults gives T+27).
- The period is loaded into pending 32 cycles later.
- `busy` is high from T+1 until return to IDLE. A new trigger is accepted only in IDLE.
- `beat_pulse` period is exactly `period` cycles, with no jitter.
- `reset` asserted at any time, including mid-divide, returns every output to 0 and FSM to IDLE, and clears `fresh`, `held`, EMA-loaded flag and pending period.

## Configuration
- **`BPM_FUSION_OCTAVE_FOLD_EN` defined.**
  - In ACCUM, an out-of-range band is folded before accumulation: doubled while below `BPM_MIN`, halved while above `BPM_MAX`.
  - Folding costs one cycle per shift, at most `BPM_W` shifts.
  - A value of 0, or a value that cannot land in range, is rejected.
  - ACCUM latency becomes variable, and `busy` covers it.
- **Undefined.** Out-of-range bands are rejected with no extra cycles.

## Test plan
- **Unanimous bands.** `CLK_HZ=1000`, weights 2,2,1; strobe 120,120,120 → `fused_bpm=120`, `fused_valid` at T+27, `locked` rises, `beat_pulse` every 500 cycles.
- **Weighted fusion.** 100,120,150 with weights 2,2,1 → raw 590/5 = 118, first load so `fused_bpm=118`.
- **Out-of-range band.** 250,120,120 with weights 2,2,1.
  - Without macro: (240+120)/3 = 120.
  - With `BPM_FUSION_OCTAVE_FOLD_EN`: 250→125, (250+240+120)/5 = 122.
- **Smoothing and period handover.** After 120 is loaded, fuse raw 160 → `fused_bpm=130`. The period changes 500→461 only after the in-progress 500-cycle beat completes.
- **Degenerate triggers.**
  - All weights 0: strobes → no trigger, `busy` stays 0.
  - Weights 0,0,1 with only band 2 strobed → triggers.
- **Reset mid-operation.** Assert `reset` during DIV1 → all outputs 0 immediately. The next strobe set behaves as first-after-reset (direct load).
